// File: rtl/ps2_guess_receiver_pkg.sv
// Shared types and scan-code constants for the PS/2 guess receiver.
// Maps keyboard make codes onto hex nibbles for the guess register.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } hex_key_t;

  function automatic hex_key_t sc_to_hex(input logic [7:0] sc);
    hex_key_t k;
    k.valid  = 1'b1;
    k.nibble = 4'h0;
    case (sc)
      8'h45: k.nibble = 4'h0;
      8'h16: k.nibble = 4'h1;
      8'h1E: k.nibble = 4'h2;
      8'h26: k.nibble = 4'h3;
      8'h25: k.nibble = 4'h4;
      8'h2E: k.nibble = 4'h5;
      8'h36: k.nibble = 4'h6;
      8'h3D: k.nibble = 4'h7;
      8'h3E: k.nibble = 4'h8;
      8'h46: k.nibble = 4'h9;
      8'h1C: k.nibble = 4'hA;
      8'h32: k.nibble = 4'hB;
      8'h21: k.nibble = 4'hC;
      8'h23: k.nibble = 4'hD;
      8'h24: k.nibble = 4'hE;
      8'h2B: k.nibble = 4'hF;
      default: k.valid = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ps2_guess_receiver_if.sv
// Output bundle of the guess receiver: guess value, strobes and diagnostics.
interface ps2_guess_receiver_if;
  logic [7:0] guess;
  logic       guess_submit;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_error;

  modport master (output guess, guess_submit, scan_code, scan_valid, frame_error);
  modport slave  (input  guess, guess_submit, scan_code, scan_valid, frame_error);
endinterface

// File: rtl/ps2_guess_receiver_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronizers, clock glitch filter,
// frame FSM with odd-parity/stop check and a mid-frame inactivity timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_scan_code,
  output logic       o_scan_valid,
  output logic       o_frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic          r_clk_meta, r_clk_sync, r_data_meta, r_data_sync;
  logic          r_filt, r_filt_q;
  logic [FW-1:0] r_filt_cnt;
  logic          w_fall;

  // NOTE: sequential state uses non-blocking assignments only; the async
  // reset presets the line-side flops to the PS/2 idle-high level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
      r_filt      <= 1'b1;
      r_filt_q    <= 1'b1;
      r_filt_cnt  <= '0;
    end else begin
      r_clk_meta  <= i_ps2_clk;
      r_clk_sync  <= r_clk_meta;
      r_data_meta <= i_ps2_data;
      r_data_sync <= r_data_meta;
      r_filt_q    <= r_filt;
      if (r_clk_sync == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_LAST) begin
        r_filt     <= r_clk_sync;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_fall = r_filt_q & ~r_filt;

  frame_state_t  r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_tmo;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_parity      <= 1'b0;
      r_tmo         <= '0;
      o_scan_code   <= '0;
      o_scan_valid  <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      o_scan_valid  <= 1'b0;
      o_frame_error <= 1'b0;
      // An edge arriving on the timeout cycle keeps the frame alive.
      if (r_state != IDLE && !w_fall && r_tmo == TMO_LAST) begin
        o_frame_error <= 1'b1;
        r_state       <= IDLE;
        r_tmo         <= '0;
      end else begin
        if (r_state == IDLE || w_fall) r_tmo <= '0;
        else                           r_tmo <= r_tmo + 1'b1;
        if (w_fall) begin
          case (r_state)
            IDLE: begin
              if (!r_data_sync) begin
                r_state   <= DATA;
                r_bit_cnt <= '0;
              end
            end
            DATA: begin
              r_shift   <= {r_data_sync, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 3'd7) r_state <= PARITY;
            end
            PARITY: begin
              r_parity <= r_data_sync;
              r_state  <= STOP;
            end
            STOP: begin
              if (r_data_sync && (^{r_shift, r_parity})) begin
                o_scan_code  <= r_shift;
                o_scan_valid <= 1'b1;
              end else begin
                o_frame_error <= 1'b1;
              end
              r_state <= IDLE;
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/ps2_guess_receiver.sv
// Top level: PS/2 frame receiver plus the keystroke decoder that builds the
// 8-bit guess from hex-digit make codes, with Enter/Backspace handling.
module ps2_guess_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  ps2_guess_receiver_if.master  bus
);

  logic [7:0] w_scan_code;
  logic       w_scan_valid;
  logic       w_frame_error;
  hex_key_t   w_key;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_ps2_clk     (ps2_clk),
    .i_ps2_data    (ps2_data),
    .o_scan_code   (w_scan_code),
    .o_scan_valid  (w_scan_valid),
    .o_frame_error (w_frame_error)
  );

  assign w_key = sc_to_hex(w_scan_code);

  logic [7:0] r_guess;
  logic       r_submit;
  logic       r_break, r_ext;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_guess  <= '0;
      r_submit <= 1'b0;
      r_break  <= 1'b0;
      r_ext    <= 1'b0;
    end else begin
      r_submit <= 1'b0;
      if (w_frame_error) begin
        r_break <= 1'b0;
        r_ext   <= 1'b0;
      end else if (w_scan_valid) begin
        if (w_scan_code == SC_BREAK) begin
          r_break <= 1'b1;
        end else if (w_scan_code == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (r_break || r_ext) begin
          // Byte following a prefix is a break or extended key: swallow it.
          r_break <= 1'b0;
          r_ext   <= 1'b0;
        end else if (w_key.valid) begin
          r_guess <= {r_guess[3:0], w_key.nibble};
        end else if (w_scan_code == SC_ENTER) begin
          r_submit <= 1'b1;
        end else if (w_scan_code == SC_BKSP) begin
          r_guess <= '0;
        end
      end
    end
  end

  assign bus.guess        = r_guess;
  assign bus.guess_submit = r_submit;
  assign bus.scan_code    = w_scan_code;
  assign bus.scan_valid   = w_scan_valid;
  assign bus.frame_error  = w_frame_error;

endmodule

// File: tb/tb_ps2_guess_receiver.sv
// Self-checking bench for ps2_guess_receiver: directed frames from the test
// plan followed by randomized keystrokes against a keystroke-level model.
module tb_ps2_guess_receiver;
  import ps2_pkg::*;

  localparam int HP  = 20;    // PS/2 half period in system clocks
  localparam int TMO = 3000;

  logic clock    = 1'b0;
  logic reset_n  = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  always #5 clock = ~clock;

  ps2_guess_receiver_if bus ();

  ps2_guess_receiver #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse counters observed from the DUT.
  int         obs_valid = 0, obs_err = 0, obs_submit = 0;
  logic [7:0] obs_submit_guess = 8'h00;

  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.scan_valid)  obs_valid++;
      if (bus.frame_error) obs_err++;
      if (bus.guess_submit) begin
        obs_submit++;
        obs_submit_guess = bus.guess;
      end
    end
  end

  // Keystroke-level reference model.
  int         exp_valid = 0, exp_err = 0, exp_submit = 0;
  logic [7:0] exp_submit_guess = 8'h00;
  logic [7:0] m_guess = 8'h00, m_scan = 8'h00;
  bit         m_prefix = 1'b0;
  logic [7:0] hex_tab [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                               8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

  task automatic model_byte(input logic [7:0] code);
    int digit = -1;
    exp_valid++;
    m_scan = code;
    if (code == SC_BREAK || code == SC_EXT) begin
      m_prefix = 1'b1;
      return;
    end
    if (m_prefix) begin
      m_prefix = 1'b0;
      return;
    end
    for (int i = 0; i < 16; i++) if (hex_tab[i] == code) digit = i;
    if (digit >= 0) begin
      m_guess = (m_guess * 16 + digit) % 256;
    end else if (code == SC_ENTER) begin
      exp_submit++;
      exp_submit_guess = m_guess;
    end else if (code == SC_BKSP) begin
      m_guess = 8'h00;
    end
  endtask

  task automatic model_error();
    exp_err++;
    m_prefix = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " scan_valid count"}, obs_valid, exp_valid);
    check({tag, " frame_error count"}, obs_err, exp_err);
    check({tag, " submit count"}, obs_submit, exp_submit);
    check({tag, " scan_code"}, bus.scan_code, m_scan);
    check({tag, " guess"}, bus.guess, m_guess);
    if (exp_submit > 0) check({tag, " submit guess"}, obs_submit_guess, exp_submit_guess);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
  endtask

  // Drives bits[0] first; each bit is presented a half period before the fall.
  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_clk(HP);
      ps2_clk = 1'b0;
      wait_clk(HP);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                            input string tag);
    logic par;
    par = ~(^code) ^ bad_par;
    send_bits({~bad_stop, par, code, 1'b0}, 11);
    wait_clk(60);
    if (bad_par || bad_stop) model_error();
    else                     model_byte(code);
    @(negedge clock);
    check_all(tag);
  endtask

  initial begin
    logic [7:0] code;
    int         kind;
    bit         bp;

    // Reset state.
    wait_clk(5);
    @(negedge clock);
    check("reset guess", bus.guess, 8'h00);
    check("reset scan_code", bus.scan_code, 8'h00);
    check("reset pulses", {bus.scan_valid, bus.guess_submit, bus.frame_error}, 3'b000);
    reset_n = 1'b1;
    wait_clk(20);

    send_frame(8'h16, 0, 0, "digit 1");
    send_frame(8'h1C, 0, 0, "digit A");
    check("guess 1A", bus.guess, 8'h1A);
    send_frame(SC_BKSP, 0, 0, "bksp");
    send_frame(8'h2E, 0, 0, "digit 5");
    send_frame(SC_BREAK, 0, 0, "break");
    send_frame(8'h2E, 0, 0, "break 5");
    send_frame(SC_ENTER, 0, 0, "enter");
    check("submitted 05", obs_submit_guess, 8'h05);

    send_frame(8'h45, 1, 0, "bad parity");
    send_frame(8'h45, 0, 1, "bad stop");

    // Partial frame then silence: timeout.
    send_bits(11'b00000_1_0110_0, 5);
    wait_clk(TMO + 200);
    model_error();
    @(negedge clock);
    check_all("timeout");
    send_frame(8'h3E, 0, 0, "after timeout");

    // Short low glitch on ps2_clk with data low must not start a frame.
    @(negedge clock);
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_clk(3);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clk(50);
    @(negedge clock);
    check_all("glitch");
    send_frame(8'h26, 0, 0, "after glitch");

    // Reset in the middle of the data bits.
    send_bits(11'b000000_101_0, 4);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midreset guess", bus.guess, 8'h00);
    check("midreset scan_code", bus.scan_code, 8'h00);
    check("midreset pulses", {bus.scan_valid, bus.guess_submit, bus.frame_error}, 3'b000);
    m_guess  = 8'h00;
    m_scan   = 8'h00;
    m_prefix = 1'b0;
    wait_clk(5);
    @(negedge clock);
    reset_n = 1'b1;
    wait_clk(20);
    send_frame(8'h32, 0, 0, "after reset");

    send_frame(SC_EXT, 0, 0, "ext");
    send_frame(SC_ENTER, 0, 0, "ext enter");
    send_frame(8'h24, 0, 0, "digit E");
    send_frame(SC_BKSP, 0, 0, "bksp clear");
    check("guess cleared", bus.guess, 8'h00);

    // Randomized keystrokes.
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      bp   = 1'b0;
      case (kind)
        0, 1, 2, 3: code = hex_tab[$urandom_range(0, 15)];
        4:          code = SC_BREAK;
        5:          code = SC_EXT;
        6:          code = SC_ENTER;
        7:          code = SC_BKSP;
        8:          code = 8'($urandom);
        default: begin
          code = 8'($urandom);
          bp   = 1'b1;
        end
      endcase
      if (bp && $urandom_range(0, 1) == 0) send_frame(code, 0, 1, $sformatf("rand%0d", n));
      else                                 send_frame(code, bp, 0, $sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
